// File: rtl/sobel_pkg.sv
// ---------------------------------------------------------------------------
// sobel_pkg
// Shared constants for the 3x3 window path. The window generator and the
// gradient stage both import this package.
//   ELEM_W    : width of one packed window element (pixel zero-extended)
//   WIN_ELEMS : elements per 3x3 window
//   WIN_W     : width of the packed window bus
//   win_idx   : LSB position of element (r,c); r=0 oldest line, c=0 oldest column
// ---------------------------------------------------------------------------
package sobel_pkg;

    localparam int ELEM_W    = 24;
    localparam int WIN_ELEMS = 9;
    localparam int WIN_W     = WIN_ELEMS * ELEM_W;

    function automatic int win_idx(input int r, input int c);
        return (r * 3 + c) * ELEM_W;
    endfunction

endpackage

// File: rtl/sobel_window_gen_if.sv
// ---------------------------------------------------------------------------
// sobel_window_gen_if
// Pixel-in / window-out handshake bundle for sobel_window_gen.
//   pix_valid/pix_data/pix_ready : raster pixel stream into the block
//   win_valid/win_data/win_ready : 3x3 window stream out of the block
//   win_row/win_col              : position of the newest (bottom-right) pixel
//   frame_done                   : pulse after the last window of a frame is taken
// Modports:
//   master : upstream pixel source and downstream window consumer
//   slave  : the window generator itself
// ---------------------------------------------------------------------------
interface sobel_window_gen_if #(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64,
    parameter int PIX_W      = 8
);
    import sobel_pkg::*;

    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam int COL_W = $clog2(IMG_WIDTH);

    logic             pix_valid;
    logic [PIX_W-1:0] pix_data;
    logic             pix_ready;
    logic             win_valid;
    logic             win_ready;
    logic [WIN_W-1:0] win_data;
    logic [ROW_W-1:0] win_row;
    logic [COL_W-1:0] win_col;
    logic             frame_done;

    modport master (
        output pix_valid, pix_data, win_ready,
        input  pix_ready, win_valid, win_data, win_row, win_col, frame_done
    );

    modport slave (
        input  pix_valid, pix_data, win_ready,
        output pix_ready, win_valid, win_data, win_row, win_col, frame_done
    );

endinterface

// File: rtl/line_buffer_ram.sv
// ---------------------------------------------------------------------------
// line_buffer_ram
// Single-port line store, read-before-write: o_rdata shows the old contents
// at i_addr for the whole cycle, and i_wdata lands on the rising edge.
// Contents are never cleared; the window logic does not use a line before
// it has been rewritten in the current frame.
//   Clock   : clock, rising edge
//   i_we    : write enable
//   i_addr  : column address
//   i_wdata : pixel to store
//   o_rdata : stored pixel at i_addr (combinational)
// ---------------------------------------------------------------------------
module line_buffer_ram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 8
) (
    input  logic                     Clock,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    assign o_rdata = r_mem[i_addr];

    always_ff @(posedge Clock) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

endmodule

// File: rtl/sobel_window_gen.sv
// ---------------------------------------------------------------------------
// sobel_window_gen
// Turns a raster pixel stream into the stream of fully-interior 3x3
// neighbourhoods (no padding), packed as 9 zero-extended ELEM_W elements.
// Two line buffers hold the previous two lines; a 3x3 register window
// shifts one column per accepted pixel; a single output register holds the
// pending window until the consumer takes it.
//   Clock : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : sobel_window_gen_if.slave (pixel in, window out, frame_done)
// ---------------------------------------------------------------------------
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64,
    parameter int PIX_W      = 8
) (
    input  logic             Clock,
    input  logic             reset,
    sobel_window_gen_if.slave bus
);

    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam int COL_W = $clog2(IMG_WIDTH);

    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic [PIX_W-1:0] r_win [3][3];
    logic             r_win_valid;
    logic [WIN_W-1:0] r_win_data;
    logic [ROW_W-1:0] r_win_row;
    logic [COL_W-1:0] r_win_col;
    logic             r_frame_done;

    logic [PIX_W-1:0] w_shift [3][3];
    logic [WIN_W-1:0] w_win_packed;
    logic [PIX_W-1:0] w_lb0_q;
    logic [PIX_W-1:0] w_lb1_q;
    logic             w_pix_ready;
    logic             w_accept;
    logic             w_handoff;
    logic             w_emit;
    logic             w_last_col;
    logic             w_last_row;

    // No skid buffer: a pending window blocks input until it is taken.
    assign w_pix_ready = !r_win_valid || bus.win_ready;
    assign w_accept    = bus.pix_valid && w_pix_ready;
    assign w_handoff   = r_win_valid && bus.win_ready;
    assign w_emit      = w_accept && (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));
    assign w_last_col  = (r_col == COL_W'(IMG_WIDTH - 1));
    assign w_last_row  = (r_row == ROW_W'(IMG_HEIGHT - 1));

    // lb0 holds the previous line, lb1 the one before; lb1 is fed from
    // lb0's old value at the same column.
    line_buffer_ram #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb0 (
        .Clock   (Clock),
        .i_we    (w_accept),
        .i_addr  (r_col),
        .i_wdata (bus.pix_data),
        .o_rdata (w_lb0_q)
    );

    line_buffer_ram #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb1 (
        .Clock   (Clock),
        .i_we    (w_accept),
        .i_addr  (r_col),
        .i_wdata (w_lb0_q),
        .o_rdata (w_lb1_q)
    );

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            w_shift[r][0] = r_win[r][1];
            w_shift[r][1] = r_win[r][2];
        end
        w_shift[0][2] = w_lb1_q;
        w_shift[1][2] = w_lb0_q;
        w_shift[2][2] = bus.pix_data;
    end

    always_comb begin
        w_win_packed = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                w_win_packed[win_idx(r, c) +: ELEM_W] = ELEM_W'(w_shift[r][c]);
            end
        end
    end

    // The window shifts on every accept, even at columns 0/1, so the
    // interior windows of a line start from a clean set of columns.
    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else if (w_accept) begin
            r_win <= w_shift;
        end
    end

    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_accept) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= w_last_row ? '0 : r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    // A new window replaces one being handed off in the same cycle.
    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            r_win_valid <= 1'b0;
            r_win_data  <= '0;
            r_win_row   <= '0;
            r_win_col   <= '0;
        end else if (w_emit) begin
            r_win_valid <= 1'b1;
            r_win_data  <= w_win_packed;
            r_win_row   <= r_row;
            r_win_col   <= r_col;
        end else if (w_handoff) begin
            r_win_valid <= 1'b0;
        end
    end

    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_handoff
                         && (r_win_row == ROW_W'(IMG_HEIGHT - 1))
                         && (r_win_col == COL_W'(IMG_WIDTH - 1));
        end
    end

    assign bus.pix_ready  = w_pix_ready;
    assign bus.win_valid  = r_win_valid;
    assign bus.win_data   = r_win_data;
    assign bus.win_row    = r_win_row;
    assign bus.win_col    = r_win_col;
    assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_sobel_window_gen.sv
// ---------------------------------------------------------------------------
// tb_sobel_window_gen
// Two instances: a 5x5 block and a 16x8 block (selected by sel). A reference
// model tracks the handshake and pulls windows from a golden queue built
// directly from the frame image; it is compared against the DUT every cycle.
// ---------------------------------------------------------------------------
module tb_sobel_window_gen;
    import sobel_pkg::*;

    logic Clock = 1'b0;
    logic reset = 1'b1;
    always #5 Clock = ~Clock;

    logic       pv  = 1'b0;
    logic [7:0] pd  = 8'h00;
    logic       wr  = 1'b1;
    logic       sel = 1'b0;

    sobel_window_gen_if #(.IMG_WIDTH(5),  .IMG_HEIGHT(5), .PIX_W(8)) bus0 ();
    sobel_window_gen_if #(.IMG_WIDTH(16), .IMG_HEIGHT(8), .PIX_W(8)) bus1 ();

    sobel_window_gen #(.IMG_WIDTH(5), .IMG_HEIGHT(5), .PIX_W(8)) dut0 (
        .Clock (Clock),
        .reset (reset),
        .bus   (bus0)
    );

    sobel_window_gen #(.IMG_WIDTH(16), .IMG_HEIGHT(8), .PIX_W(8)) dut1 (
        .Clock (Clock),
        .reset (reset),
        .bus   (bus1)
    );

    assign bus0.pix_valid = pv && !sel;
    assign bus0.pix_data  = pd;
    assign bus0.win_ready = wr;
    assign bus1.pix_valid = pv && sel;
    assign bus1.pix_data  = pd;
    assign bus1.win_ready = wr;

    logic             o_pr, o_v, o_fd;
    logic [WIN_W-1:0] o_data;
    int               o_row, o_col;

    always_comb begin
        o_pr   = sel ? bus1.pix_ready  : bus0.pix_ready;
        o_v    = sel ? bus1.win_valid  : bus0.win_valid;
        o_fd   = sel ? bus1.frame_done : bus0.frame_done;
        o_data = sel ? bus1.win_data   : bus0.win_data;
        o_row  = sel ? int'(bus1.win_row) : int'(bus0.win_row);
        o_col  = sel ? int'(bus1.win_col) : int'(bus0.win_col);
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [WIN_W-1:0] act, input logic [WIN_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [WIN_W-1:0] data;
        int               row;
        int               col;
    } win_t;

    win_t exp_q[$];
    win_t log_q[$];
    win_t ref2[$];
    int   cur_w = 5;
    int   cur_h = 5;

    function automatic logic [7:0] pix_val(input int r, input int c, input int base);
        return 8'(r * 16 + c + base);
    endfunction

    function automatic int elem(input logic [WIN_W-1:0] d, input int r, input int c);
        return int'(d[(r * 3 + c) * 24 +: 24]);
    endfunction

    // Golden windows of one frame, in raster order of their bottom-right pixel.
    task automatic push_frame(input int base);
        win_t w;
        for (int r = 2; r < cur_h; r++) begin
            for (int c = 2; c < cur_w; c++) begin
                w.data = '0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        w.data[(i * 3 + j) * 24 +: 24] = {16'h0000, pix_val(r - 2 + i, c - 2 + j, base)};
                w.row = r;
                w.col = c;
                exp_q.push_back(w);
            end
        end
    endtask

    // Reference model: handshake state and position, checked at every negedge.
    int   mrow = 0, mcol = 0;
    bit   mv = 0, mfd = 0;
    win_t cur;
    int   n_valid = 0, n_fd = 0;
    bit   m_hand, m_acc;

    always @(negedge Clock) begin
        if (reset) begin
            mrow = 0;
            mcol = 0;
            mv   = 0;
            mfd  = 0;
        end else begin
            chk("win_valid", WIN_W'(o_v), WIN_W'(mv));
            if (mv) begin
                chk("win_data", o_data, cur.data);
                chk("win_row", WIN_W'(o_row), WIN_W'(cur.row));
                chk("win_col", WIN_W'(o_col), WIN_W'(cur.col));
            end
            chk("frame_done", WIN_W'(o_fd), WIN_W'(mfd));
            chk("pix_ready", WIN_W'(o_pr), WIN_W'(!mv || wr));
            if (o_v) n_valid++;
            if (o_fd) n_fd++;
            m_hand = mv && wr;
            m_acc  = pv && (!mv || wr);
            if (m_hand) begin
                win_t w;
                w.data = o_data;
                w.row  = o_row;
                w.col  = o_col;
                log_q.push_back(w);
            end
            mfd = m_hand && (cur.row == cur_h - 1) && (cur.col == cur_w - 1);
            if (m_acc && mrow >= 2 && mcol >= 2) begin
                if (exp_q.size() == 0) begin
                    chk("golden_queue_empty", WIN_W'(0), WIN_W'(1));
                    mv = 0;
                end else begin
                    cur = exp_q.pop_front();
                    mv  = 1;
                end
            end else if (m_hand) begin
                mv = 0;
            end
            if (m_acc) begin
                if (mcol == cur_w - 1) begin
                    mcol = 0;
                    mrow = (mrow == cur_h - 1) ? 0 : mrow + 1;
                end else begin
                    mcol = mcol + 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic send_pix(input logic [7:0] v);
        int  guard = 0;
        bit  ok;
        pv = 1'b1;
        pd = v;
        forever begin
            @(negedge Clock);
            ok = o_pr;
            @(posedge Clock);
            #1;
            if (ok) break;
            guard++;
            if (guard > 200) begin
                chk("accept_timeout", WIN_W'(0), WIN_W'(1));
                break;
            end
        end
        pv = 1'b0;
    endtask

    task automatic send_frame(input int base, input int gap_max);
        for (int r = 0; r < cur_h; r++) begin
            for (int c = 0; c < cur_w; c++) begin
                if (gap_max > 0) repeat ($urandom_range(0, gap_max)) tick();
                send_pix(pix_val(r, c, base));
            end
        end
    endtask

    task automatic drain();
        int guard = 0;
        while ((mv || exp_q.size() != 0) && guard < 500) begin
            tick();
            guard++;
        end
        if (guard >= 500) chk("drain_timeout", WIN_W'(0), WIN_W'(1));
        repeat (3) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pv    = 1'b0;
        exp_q.delete();
        @(negedge Clock);
        tick();
        reset = 1'b0;
        tick();
        log_q.delete();
        n_fd    = 0;
        n_valid = 0;
    endtask

    task automatic hold_first();
        int               guard = 0;
        logic [WIN_W-1:0] held;
        do begin
            @(negedge Clock);
            guard++;
        end while (!o_v && guard < 200);
        chk("t3_valid_seen", WIN_W'(o_v), WIN_W'(1));
        held = o_data;
        repeat (4) begin
            @(negedge Clock);
            chk("t3_pix_ready_low", WIN_W'(o_pr), WIN_W'(0));
            chk("t3_data_held", o_data, held);
        end
        @(posedge Clock);
        #1;
        wr = 1'b1;
    endtask

    bit rnd_done = 0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Test 1: reset values, then no window during the first 12 pixels.
        repeat (2) @(negedge Clock);
        chk("rst_win_valid", WIN_W'(bus0.win_valid), WIN_W'(0));
        chk("rst_win_data", bus0.win_data, WIN_W'(0));
        chk("rst_win_row", WIN_W'(bus0.win_row), WIN_W'(0));
        chk("rst_win_col", WIN_W'(bus0.win_col), WIN_W'(0));
        chk("rst_frame_done", WIN_W'(bus0.frame_done), WIN_W'(0));
        chk("rst_pix_ready", WIN_W'(bus0.pix_ready), WIN_W'(1));
        @(posedge Clock);
        #1;
        reset = 1'b0;
        tick();
        for (int k = 0; k < 12; k++) send_pix(pix_val(k / 5, k % 5, 0));
        tick();
        chk("t1_no_valid", WIN_W'(n_valid), WIN_W'(0));

        // Test 2: full 5x5 frame, consumer always ready.
        do_reset();
        push_frame(0);
        send_frame(0, 0);
        drain();
        chk("t2_count", WIN_W'(log_q.size()), WIN_W'(9));
        if (log_q.size() == 9) begin
            chk("t2_first_row", WIN_W'(log_q[0].row), WIN_W'(2));
            chk("t2_first_col", WIN_W'(log_q[0].col), WIN_W'(2));
            chk("t2_e00", WIN_W'(elem(log_q[0].data, 0, 0)), WIN_W'(0));
            chk("t2_e02", WIN_W'(elem(log_q[0].data, 0, 2)), WIN_W'(2));
            chk("t2_e11", WIN_W'(elem(log_q[0].data, 1, 1)), WIN_W'(17));
            chk("t2_e22", WIN_W'(elem(log_q[0].data, 2, 2)), WIN_W'(34));
            chk("t2_last_e22", WIN_W'(elem(log_q[8].data, 2, 2)), WIN_W'(68));
        end
        chk("t2_frame_done", WIN_W'(n_fd), WIN_W'(1));
        ref2 = log_q;

        // Test 3: stall the first window for 4 cycles.
        do_reset();
        wr = 1'b0;
        push_frame(0);
        fork
            send_frame(0, 0);
            hold_first();
        join
        drain();
        chk("t3_count", WIN_W'(log_q.size()), WIN_W'(9));
        if (log_q.size() > 1)
            chk("t3_second_e22", WIN_W'(elem(log_q[1].data, 2, 2)), WIN_W'(35));
        chk("t3_frame_done", WIN_W'(n_fd), WIN_W'(1));

        // Test 4: 16x8 frame with random input gaps and random back-pressure.
        sel   = 1'b1;
        cur_w = 16;
        cur_h = 8;
        do_reset();
        push_frame(3);
        rnd_done = 0;
        fork
            begin
                send_frame(3, 3);
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    wr = 1'($urandom_range(0, 1));
                    tick();
                end
                wr = 1'b1;
            end
        join
        drain();
        chk("t4_count", WIN_W'(log_q.size()), WIN_W'(84));
        chk("t4_frame_done", WIN_W'(n_fd), WIN_W'(1));

        // Test 5: two back-to-back 5x5 frames.
        sel   = 1'b0;
        cur_w = 5;
        cur_h = 5;
        do_reset();
        push_frame(0);
        push_frame(1);
        send_frame(0, 0);
        send_frame(1, 0);
        drain();
        chk("t5_count", WIN_W'(log_q.size()), WIN_W'(18));
        chk("t5_frame_done", WIN_W'(n_fd), WIN_W'(2));
        if (log_q.size() == 18) begin
            chk("t5_f2_e00", WIN_W'(elem(log_q[9].data, 0, 0)), WIN_W'(1));
            chk("t5_f2_last_e22", WIN_W'(elem(log_q[17].data, 2, 2)), WIN_W'(69));
        end

        // Test 6: reset after 13 pixels, then a clean frame.
        do_reset();
        push_frame(0);
        for (int k = 0; k < 13; k++) send_pix(pix_val(k / 5, k % 5, 0));
        do_reset();
        push_frame(0);
        send_frame(0, 0);
        drain();
        chk("t6_count", WIN_W'(log_q.size()), WIN_W'(9));
        chk("t6_frame_done", WIN_W'(n_fd), WIN_W'(1));
        if (log_q.size() == 9 && ref2.size() == 9) begin
            for (int i = 0; i < 9; i++) begin
                chk($sformatf("t6_data_%0d", i), log_q[i].data, ref2[i].data);
                chk($sformatf("t6_row_%0d", i), WIN_W'(log_q[i].row), WIN_W'(ref2[i].row));
                chk($sformatf("t6_col_%0d", i), WIN_W'(log_q[i].col), WIN_W'(ref2[i].col));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
